vector_gates_rx: RTL and testbench
==================================

VECTOR_GATES_RX -- requirements
Module: vector_gates_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning the operand width in bits; frame length is 2*WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_bit and in_last are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a serial beat this cycle.
REQ-006 SHALL have port in_bit, input, 1 bit: one serial bit of the packed inverted frame.
REQ-007 SHALL have port in_last, input, 1 bit: marks the final beat of a frame.
REQ-008 SHALL have port out_valid, output, 1 bit: the decoded result is held valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_a, output, WIDTH bits: recovered operand a.
REQ-011 SHALL have port out_b, output, WIDTH bits: recovered operand b.
REQ-012 SHALL have port out_or_bitwise, output, WIDTH bits: out_a | out_b.
REQ-013 SHALL have port out_or_logical, output, 1 bit: 1 iff (out_a | out_b) != 0.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a malformed frame.

Function
REQ-015 SHALL transfer a beat only when in_valid && in_ready at a rising clk edge.
REQ-016 SHALL shift beats LSB-first into a 2*WIDTH-bit word: the first beat goes to word[0], the last beat to word[2*WIDTH-1].
REQ-017 SHALL decode the frame as word[WIDTH-1:0] = ~a and word[2*WIDTH-1:WIDTH] = ~b, so out_a = ~word low half and out_b = ~word high half.
REQ-018 SHALL track received beats with a counter cnt running 0..2*WIDTH-1.
REQ-019 SHALL, on a beat accepted with cnt == 2*WIDTH-1 and in_last == 1, register all four results and assert out_valid on the next cycle (latency 1), then set cnt to 0.
REQ-020 SHALL, on a beat accepted with cnt == 2*WIDTH-1 and in_last == 0, pulse frame_err for one cycle, discard the frame, set cnt to 0, and leave the output registers and out_valid unchanged.
REQ-021 SHALL, on a beat accepted with cnt < 2*WIDTH-1 and in_last == 1, pulse frame_err for one cycle, discard the frame, and set cnt to 0.
REQ-022 SHALL drive in_ready = 0 only when cnt == 2*WIDTH-1 && out_valid && !out_ready; in_ready SHALL be 1 otherwise, including the earlier beats of a frame while a result is still held.
REQ-023 SHALL hold out_* stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid after out_valid && out_ready, unless a new frame completes in the same cycle, in which case out_valid stays 1 with the new values loaded.
REQ-025 SHALL ignore in_bit and in_last when in_valid == 0; cnt and shift state are retained.

Reset
REQ-026 SHALL, while rst_n == 0 and independent of clk, force cnt = 0, shift word = 0, out_valid = 0, frame_err = 0, out_a = out_b = out_or_bitwise = 0, and out_or_logical = 0.
REQ-027 SHALL, on reset assertion mid-frame, discard the partial frame; the first beat accepted after release is bit 0 of a new frame.
REQ-028 SHALL drive in_ready = 1 during and immediately after reset.

Structure
REQ-029 SHALL place the default WIDTH and the frame-length constant 2*WIDTH in the shared basics package.
REQ-030 SHALL be a single module with no sub-modules; decode logic is an inline continuous assignment feeding the output registers.

Verification
REQ-031 SHALL cover a=3'b101, b=3'b010: send in_bit 0,1,0,1,0,1 with in_last on the 6th beat -> next cycle out_valid=1, out_a=101, out_b=010, out_or_bitwise=111, out_or_logical=1.
REQ-032 SHALL cover a=0, b=0: send six 1 bits -> out_a=000, out_b=000, out_or_bitwise=000, out_or_logical=0.
REQ-033 SHALL cover in_last asserted on the 4th beat -> frame_err pulses for 1 cycle, out_valid stays 0, and the next good 6-beat frame decodes correctly.
REQ-034 SHALL cover out_ready held 0 across two back-to-back frames -> in_ready=0 at the 6th beat of frame 2, frame-1 data is stable, and frame 2 appears the cycle after out_ready=1.
REQ-035 SHALL cover rst_n pulsed low after 3 beats -> all outputs 0 immediately, and a fresh 6-beat frame decodes correctly.
REQ-036 SHALL cover out_ready=1 in the same cycle as a 6th-beat completion -> out_valid remains 1 with the new frame's values.

Source files
------------

// File: rtl/vector_gates_rx_pkg.sv
// Shared basics for the vector_gates_rx serial receiver.
//   DEFAULT_WIDTH     : default operand width in bits
//   DEFAULT_FRAME_LEN : serial frame length for the default width (2*WIDTH)
//   frame_len()       : frame length for an arbitrary operand width
package vector_gates_rx_pkg;

   localparam int unsigned DEFAULT_WIDTH     = 3;
   localparam int unsigned DEFAULT_FRAME_LEN = 2 * DEFAULT_WIDTH;

   function automatic int unsigned frame_len(input int unsigned width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/vector_gates_rx.sv
// vector_gates_rx: serial receiver that collects a 2*WIDTH-bit frame LSB-first,
// decodes two inverted operands and presents them with their bitwise/logical OR.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : serial beat handshake; in_bit carries data, in_last ends a frame
//   out_valid/out_ready : result handshake; results held while out_valid && !out_ready
//   out_a, out_b      : recovered operands (frame halves inverted)
//   out_or_bitwise    : out_a | out_b
//   out_or_logical    : 1 iff out_a | out_b is non-zero
//   frame_err         : one-cycle pulse when in_last does not coincide with the final beat
module vector_gates_rx
   import vector_gates_rx_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_or_bitwise,
   output logic             out_or_logical,
   output logic             frame_err
);

   localparam int unsigned FRAME_LEN = frame_len(WIDTH);
   localparam int unsigned CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   logic [CNT_W-1:0]     cnt;
   logic [FRAME_LEN-1:0] word;
   logic [FRAME_LEN-1:0] word_next;
   logic [WIDTH-1:0]     dec_a;
   logic [WIDTH-1:0]     dec_b;
   logic                 at_last;
   logic                 accept;
   logic                 frame_done;
   logic                 frame_bad;

   assign at_last = (cnt == LAST_CNT);

   // Only the completing beat can be stalled: earlier beats never touch the
   // held result, so they are accepted even while out_valid waits.
   assign in_ready = !(at_last && out_valid && !out_ready);
   assign accept   = in_valid && in_ready;

   // Right shift lands the first beat in word[0] once all beats have arrived.
   assign word_next = {in_bit, word[FRAME_LEN-1:1]};

   assign dec_a = ~word_next[WIDTH-1:0];
   assign dec_b = ~word_next[FRAME_LEN-1:WIDTH];

   assign frame_done = accept && at_last && in_last;
   // Malformed: last flag missing on the final beat, or present on an earlier one.
   assign frame_bad  = accept && (at_last != in_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         word <= '0;
      end else if (accept) begin
         if (at_last || in_last) begin
            cnt  <= '0;
            word <= '0;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            word <= word_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_a          <= '0;
         out_b          <= '0;
         out_or_bitwise <= '0;
         out_or_logical <= 1'b0;
         frame_err      <= 1'b0;
      end else begin
         frame_err <= frame_bad;
         if (frame_done) begin
            out_valid      <= 1'b1;
            out_a          <= dec_a;
            out_b          <= dec_b;
            out_or_bitwise <= dec_a | dec_b;
            out_or_logical <= |(dec_a | dec_b);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vector_gates_rx.sv
module tb_vector_gates_rx;
   import vector_gates_rx_pkg::*;

   localparam int unsigned W     = DEFAULT_WIDTH;
   localparam int unsigned FRAME = 2 * W;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         in_bit;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_a;
   logic [W-1:0] out_b;
   logic [W-1:0] out_or_bitwise;
   logic         out_or_logical;
   logic         frame_err;

   vector_gates_rx #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_bit         (in_bit),
      .in_last        (in_last),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_a          (out_a),
      .out_b          (out_b),
      .out_or_bitwise (out_or_bitwise),
      .out_or_logical (out_or_logical),
      .frame_err      (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: received bits of the current frame plus the held result.
   bit           bits[$];
   logic         m_valid;
   logic [W-1:0] m_a;
   logic [W-1:0] m_b;
   logic         m_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [FRAME-1:0] enc(input logic [W-1:0] a, input logic [W-1:0] b);
      return {~b, ~a};
   endfunction

   task automatic model_clear();
      bits.delete();
      m_valid = 1'b0;
      m_a     = '0;
      m_b     = '0;
      m_err   = 1'b0;
   endtask

   task automatic check_outputs();
      check_eq("out_valid",      out_valid,      m_valid);
      check_eq("out_a",          out_a,          m_a);
      check_eq("out_b",          out_b,          m_b);
      check_eq("out_or_bitwise", out_or_bitwise, m_a | m_b);
      check_eq("out_or_logical", out_or_logical, (m_a | m_b) != 0);
      check_eq("frame_err",      frame_err,      m_err);
   endtask

   // One clock cycle: drive after the falling edge, check in_ready before the
   // rising edge, advance the model at the edge, check outputs just after it.
   task automatic step(input logic v, input logic b, input logic l, input logic r);
      logic exp_ready;
      logic acc;
      in_valid  = v;
      in_bit    = b;
      in_last   = l;
      out_ready = r;
      #1;
      exp_ready = !((bits.size() == FRAME - 1) && m_valid && !r);
      check_eq("in_ready", in_ready, exp_ready);
      acc = v && exp_ready;
      @(posedge clk);
      m_err = 1'b0;
      if (m_valid && r) m_valid = 1'b0;
      if (acc) begin
         bits.push_back(b);
         if (bits.size() == FRAME) begin
            if (l) begin
               for (int i = 0; i < W; i++) begin
                  m_a[i] = !bits[i];
                  m_b[i] = !bits[W + i];
               end
               m_valid = 1'b1;
            end else begin
               m_err = 1'b1;
            end
            bits.delete();
         end else if (l) begin
            m_err = 1'b1;
            bits.delete();
         end
      end
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [FRAME-1:0] w, input int last_at, input logic r);
      for (int i = 0; i < FRAME; i++) begin
         step(1'b1, w[i], (i == last_at), r);
         if (i == last_at) break;
      end
   endtask

   task automatic pulse_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_eq("rst_in_ready",  in_ready,  1'b1);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_a",     out_a,     '0);
      check_eq("rst_out_b",     out_b,     '0);
      check_eq("rst_or_bitw",   out_or_bitwise, '0);
      check_eq("rst_or_log",    out_or_logical, 1'b0);
      check_eq("rst_frame_err", frame_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [FRAME-1:0] w1;
      logic [FRAME-1:0] w2;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      check_outputs();
      check_eq("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;

      // a=101, b=010
      send_frame(enc(3'b101, 3'b010), FRAME - 1, 1'b0);
      check_eq("ex1_a",   out_a,          3'b101);
      check_eq("ex1_b",   out_b,          3'b010);
      check_eq("ex1_or",  out_or_bitwise, 3'b111);
      check_eq("ex1_log", out_or_logical, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // a=0, b=0
      send_frame(enc(3'b000, 3'b000), FRAME - 1, 1'b1);
      check_eq("ex2_a",   out_a,          3'b000);
      check_eq("ex2_log", out_or_logical, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // in_last on beat 4, then a good frame
      send_frame(enc(3'b110, 3'b011), 3, 1'b1);
      check_eq("err4_pulse", frame_err, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("err4_clear", frame_err, 1'b0);
      send_frame(enc(3'b110, 3'b011), FRAME - 1, 1'b1);
      check_eq("after_err_a", out_a, 3'b110);
      check_eq("after_err_b", out_b, 3'b011);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // back-to-back frames with consumer stalled
      w1 = enc(3'b001, 3'b100);
      w2 = enc(3'b111, 3'b010);
      send_frame(w1, FRAME - 1, 1'b0);
      for (int i = 0; i < FRAME - 1; i++) step(1'b1, w2[i], 1'b0, 1'b0);
      repeat (2) step(1'b1, w2[FRAME-1], 1'b1, 1'b0);
      check_eq("stall_a1", out_a, 3'b001);
      check_eq("stall_b1", out_b, 3'b100);
      step(1'b1, w2[FRAME-1], 1'b1, 1'b1);
      check_eq("stall_a2", out_a, 3'b111);
      check_eq("stall_b2", out_b, 3'b010);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // reset after three beats, then a fresh frame
      w1 = enc(3'b011, 3'b101);
      for (int i = 0; i < 3; i++) step(1'b1, w1[i], 1'b0, 1'b1);
      pulse_reset();
      send_frame(w1, FRAME - 1, 1'b0);
      check_eq("post_rst_a", out_a, 3'b011);
      check_eq("post_rst_b", out_b, 3'b101);

      // completion in the same cycle the held result is consumed
      w2 = enc(3'b100, 3'b001);
      for (int i = 0; i < FRAME - 1; i++) step(1'b1, w2[i], 1'b0, 1'b0);
      step(1'b1, w2[FRAME-1], 1'b1, 1'b1);
      check_eq("same_cyc_valid", out_valid, 1'b1);
      check_eq("same_cyc_a",     out_a,     3'b100);
      check_eq("same_cyc_b",     out_b,     3'b001);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         logic v, b, l, r;
         if ($urandom_range(0, 299) == 0) begin
            pulse_reset();
         end else begin
            v = ($urandom_range(0, 3) != 0);
            b = $urandom_range(0, 1);
            r = ($urandom_range(0, 2) != 0);
            if (bits.size() == FRAME - 1) l = ($urandom_range(0, 7) != 0);
            else                          l = ($urandom_range(0, 15) == 0);
            step(v, b, l, r);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
